dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter BITS, default 64, data word width.
REQ-002 Parameter DEPTH, default 32, memory words; word index width is 5 at default.
REQ-003 clk input 1: single clock; all state updates on posedge clk.
REQ-004 rst_n input 1: synchronous active-low reset, sampled on posedge clk.
REQ-005 cN_req input 1 (N = 0 core, 1 loader): access request; held, with its fields stable, until cN_ack.
REQ-006 cN_we input 1: 1 store, 0 load.
REQ-007 cN_addr input 8: byte address; [7:3] word index, [2:0] byte offset.
REQ-008 cN_size input 2: 00 byte, 01 half, 10 word, 11 double.
REQ-009 cN_uns input 1: load zero-extend when 1, sign-extend when 0.
REQ-010 cN_wdata input BITS: store data, right-aligned.
REQ-011 cN_ack output 1: one-cycle completion pulse.
REQ-012 cN_rdata output BITS: load result, valid in the ack cycle.
REQ-013 cN_err output 1: misaligned access, pulses with cN_ack.
REQ-014 mem_endr output 5, mem_We output 1, mem_din output BITS: drive the memory's endr, We and din pins.
REQ-015 mem_dout input BITS: memory's combinational read data.
REQ-016 busy output 1: high in every state except IDLE.

Function
REQ-017 States: IDLE, ACCESS, MERGE, ACK.
REQ-018 IDLE: requests are sampled only here. If any cN_req=1, latch the winner's fields and go to ACCESS; otherwise stay in IDLE.
REQ-019 Arbitration is round-robin on last_grant: a sole requester wins; on simultaneous requests, the requester not equal to last_grant wins.
REQ-020 last_grant updates at grant.
REQ-021 Misaligned access: offset not a multiple of the size in bytes (half: off[0] != 0; word: off[1:0] != 0; double: off != 0).
REQ-022 Misaligned access path: IDLE -> ACK with err=1; no mem_We; rdata = 0.
REQ-023 ACCESS drives mem_endr = latched word index.
REQ-024 ACCESS, load: capture mem_dout; go to ACK.
REQ-025 ACCESS, double store: mem_We=1, mem_din=wdata; go to ACK.
REQ-026 ACCESS, sub-double store: capture mem_dout, mem_We=0; go to MERGE.
REQ-027 MERGE: mem_We=1; mem_din = captured word with bytes [off, off+size) replaced by the low wdata bytes; all other bytes unchanged; go to ACK.
REQ-028 ACK: pulse the granted cN_ack for exactly one cycle; go to IDLE.
REQ-029 Load result = captured word >> (8*off), truncated to size, then zero- or sign-extended to BITS per cN_uns; size 11 ignores cN_uns.
REQ-030 Latency, req high in IDLE to ack: load and double store 2 cycles; sub-word store 3 cycles; misaligned 1 cycle.
REQ-031 A requester holding req after its ack is re-arbitrated in the next IDLE cycle as a new transaction.
REQ-032 mem_We is 0 in every state except the single write cycle; at most one memory write per transaction.
REQ-033 The non-granted requester's ack, err and rdata stay 0 throughout.
REQ-034 Latched fields ignore input changes after grant.

Reset
REQ-035 While rst_n=0 at posedge: state IDLE, last_grant=1 (core wins first tie), all ack/err 0, all rdata 0, mem_We 0, mem_endr 0, mem_din 0, busy 0.
REQ-036 Reset mid-transaction aborts it with no ack; a pending MERGE write is suppressed.

Structure
REQ-037 Shared package dmem_pkg holds the size encodings, the state enum, and the BITS/DEPTH defaults.
REQ-038 One combinational sub-module, dmem_lane_merge, performs store byte-merge and load extract/extend; the FSM and arbiter stay in dmem_arbiter.

Verification
REQ-039 Memory word 3 = 0x1122334455667788; c0 loads byte at addr 0x1F, uns=0 -> 2 cycles later c0_ack=1, c0_rdata=0x0000000000000011.
REQ-040 Word 3 as above; c0 stores half 0xBEEF at addr 0x1A -> mem_We only in MERGE; word 3 becomes 0x11223344BEEF7788; ack on cycle 3.
REQ-041 c0 and c1 raise req in the same cycle after reset -> c0 granted first, then c1; with both held high, grants alternate c0, c1, c0.
REQ-042 c1 loads word at addr 0x06 -> c1_ack and c1_err=1 next cycle, no mem_We, c1_rdata=0.
REQ-043 rst_n low during MERGE of a byte store -> no memory write, no ack, state IDLE, busy=0.
REQ-044 Signed word load of 0x00000000_80000000 at addr 0x08 -> rdata 0xFFFFFFFF80000000; same with uns=1 -> 0x0000000080000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, size encodings and defaults for the data-memory arbiter.
package dmem_pkg;

  localparam int BITS_DEF  = 64;
  localparam int DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_MERGE  = 2'b10,
    ST_ACK    = 2'b11
  } state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_BYTE:   mis = 1'b0;
      SZ_HALF:   mis = off[0];
      SZ_WORD:   mis = |off[1:0];
      SZ_DOUBLE: mis = |off;
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane datapath: store byte-merge into a memory word and load extract/extend.
module dmem_lane_merge
  import dmem_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic [BITS-1:0] word_i,
  input  logic [BITS-1:0] wdata_i,
  input  logic [2:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  output logic [BITS-1:0] merged_o,
  output logic [BITS-1:0] load_o
);

  logic [5:0]      sh_s;
  logic [BITS-1:0] mask_s;
  logic [BITS-1:0] lane_mask_s;
  logic [BITS-1:0] shifted_s;

  assign sh_s        = {off_i, 3'b000};
  assign lane_mask_s = mask_s << sh_s;
  assign merged_o    = (word_i & ~lane_mask_s) | ((wdata_i << sh_s) & lane_mask_s);
  assign shifted_s   = word_i >> sh_s;

  // Right-aligned byte mask covering the access size.
  always_comb begin
    mask_s = {BITS{1'b0}};
    case (size_i)
      SZ_BYTE:   mask_s[7:0]  = {8{1'b1}};
      SZ_HALF:   mask_s[15:0] = {16{1'b1}};
      SZ_WORD:   mask_s[31:0] = {32{1'b1}};
      SZ_DOUBLE: mask_s       = {BITS{1'b1}};
      default:   mask_s       = {BITS{1'b0}};
    endcase
  end

  // Truncate the shifted word to the access size and extend; sign bit is forced low for unsigned.
  always_comb begin
    load_o = {BITS{1'b0}};
    case (size_i)
      SZ_BYTE:   load_o = {{(BITS-8){~uns_i & shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF:   load_o = {{(BITS-16){~uns_i & shifted_s[15]}}, shifted_s[15:0]};
      SZ_WORD:   load_o = {{(BITS-32){~uns_i & shifted_s[31]}}, shifted_s[31:0]};
      SZ_DOUBLE: load_o = shifted_s;
      default:   load_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a single-port data memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     c0_req,
  input  logic                     c0_we,
  input  logic [7:0]               c0_addr,
  input  logic [1:0]               c0_size,
  input  logic                     c0_uns,
  input  logic [BITS-1:0]          c0_wdata,
  output logic                     c0_ack,
  output logic [BITS-1:0]          c0_rdata,
  output logic                     c0_err,
  input  logic                     c1_req,
  input  logic                     c1_we,
  input  logic [7:0]               c1_addr,
  input  logic [1:0]               c1_size,
  input  logic                     c1_uns,
  input  logic [BITS-1:0]          c1_wdata,
  output logic                     c1_ack,
  output logic [BITS-1:0]          c1_rdata,
  output logic                     c1_err,
  output logic [$clog2(DEPTH)-1:0] mem_endr,
  output logic                     mem_We,
  output logic [BITS-1:0]          mem_din,
  input  logic [BITS-1:0]          mem_dout,
  output logic                     busy
);

  localparam int IW = $clog2(DEPTH);

  state_e          state_q, state_d;
  logic            grant_q, grant_d;   // last granted requester; also owner of the live transaction
  logic            we_q, we_d;
  logic [2:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic            mem_we_q, mem_we_d;
  logic [IW-1:0]   endr_q, endr_d;
  logic [BITS-1:0] din_q, din_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic [BITS-1:0] rdata0_q, rdata0_d;
  logic [BITS-1:0] rdata1_q, rdata1_d;
  logic            busy_q, busy_d;

  logic            pick_s;
  logic            sel_we_s;
  logic [7:0]      sel_addr_s;
  logic [1:0]      sel_size_s;
  logic            sel_uns_s;
  logic [BITS-1:0] sel_wdata_s;
  logic [BITS-1:0] merged_s;
  logic [BITS-1:0] load_s;

  dmem_lane_merge #(.BITS(BITS)) u_lane (
    .word_i   (mem_dout),
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .merged_o (merged_s),
    .load_o   (load_s)
  );

  // Round-robin pick: sole requester wins, a tie goes to the one not granted last.
  always_comb begin
    pick_s = c1_req & (~c0_req | ~grant_q);
    if (pick_s) begin
      sel_we_s    = c1_we;
      sel_addr_s  = c1_addr;
      sel_size_s  = c1_size;
      sel_uns_s   = c1_uns;
      sel_wdata_s = c1_wdata;
    end else begin
      sel_we_s    = c0_we;
      sel_addr_s  = c0_addr;
      sel_size_s  = c0_size;
      sel_uns_s   = c0_uns;
      sel_wdata_s = c0_wdata;
    end
  end

  // Next-state and next-output logic; memory strobes and acks are registered on entry to their state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    mem_we_d = 1'b0;
    endr_d   = endr_q;
    din_d    = din_q;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = {BITS{1'b0}};
    rdata1_d = {BITS{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (c0_req | c1_req) begin
          grant_d = pick_s;
          we_d    = sel_we_s;
          off_d   = sel_addr_s[2:0];
          size_d  = sel_size_s;
          uns_d   = sel_uns_s;
          wdata_d = sel_wdata_s;
          if (is_misaligned(sel_addr_s[2:0], sel_size_s)) begin
            state_d = ST_ACK;
            ack_d   = pick_s ? 2'b10 : 2'b01;
            err_d   = pick_s ? 2'b10 : 2'b01;
          end else begin
            state_d = ST_ACCESS;
            endr_d  = IW'(sel_addr_s[7:3]);
            if (sel_we_s && (sel_size_s == SZ_DOUBLE)) begin
              mem_we_d = 1'b1;
              din_d    = sel_wdata_s;
            end else begin
              mem_we_d = 1'b0;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (we_q && (size_q != SZ_DOUBLE)) begin
          state_d  = ST_MERGE;
          mem_we_d = 1'b1;
          din_d    = merged_s;
        end else begin
          state_d = ST_ACK;
          ack_d   = grant_q ? 2'b10 : 2'b01;
          if (we_q) begin
            rdata0_d = {BITS{1'b0}};
            rdata1_d = {BITS{1'b0}};
          end else begin
            rdata0_d = grant_q ? {BITS{1'b0}} : load_s;
            rdata1_d = grant_q ? load_s : {BITS{1'b0}};
          end
        end
      end
      ST_MERGE: begin
        state_d = ST_ACK;
        ack_d   = grant_q ? 2'b10 : 2'b01;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b1;
      we_q     <= 1'b0;
      off_q    <= 3'd0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      wdata_q  <= {BITS{1'b0}};
      mem_we_q <= 1'b0;
      endr_q   <= {IW{1'b0}};
      din_q    <= {BITS{1'b0}};
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= {BITS{1'b0}};
      rdata1_q <= {BITS{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      mem_we_q <= mem_we_d;
      endr_q   <= endr_d;
      din_q    <= din_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign c0_ack   = ack_q[0];
  assign c1_ack   = ack_q[1];
  assign c0_err   = err_q[0];
  assign c1_err   = err_q[1];
  assign c0_rdata = rdata0_q;
  assign c1_rdata = rdata1_q;
  assign mem_endr = endr_q;
  // Gating with rst_n keeps a reset asserted in the write cycle from committing that write.
  assign mem_We   = mem_we_q & rst_n;
  assign mem_din  = din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a byte-level reference model.
module tb_dmem_arbiter;

  localparam int BITS  = 64;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c0_req, c0_we, c0_uns, c0_ack, c0_err;
  logic [7:0]  c0_addr;
  logic [1:0]  c0_size;
  logic [63:0] c0_wdata, c0_rdata;
  logic        c1_req, c1_we, c1_uns, c1_ack, c1_err;
  logic [7:0]  c1_addr;
  logic [1:0]  c1_size;
  logic [63:0] c1_wdata, c1_rdata;
  logic [4:0]  mem_endr;
  logic        mem_We, busy;
  logic [63:0] mem_din, mem_dout;

  logic [63:0] mem [DEPTH];
  logic [63:0] model [DEPTH];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_idx = 5'd0;
  logic [63:0] bd_val = 64'd0;
  int          wr_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_model = 1;
  int          first_acked;
  logic [63:0] last_rd [2];

  dmem_arbiter #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_size(c0_size), .c0_uns(c0_uns),
    .c0_wdata(c0_wdata), .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_size(c1_size), .c1_uns(c1_uns),
    .c1_wdata(c1_wdata), .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .mem_endr(mem_endr), .mem_We(mem_We), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, write on clock edge; a backdoor port preloads contents.
  assign mem_dout = mem[mem_endr];
  always @(posedge clk) begin
    if (mem_We) begin
      mem[mem_endr] <= mem_din;
      wr_cnt        <= wr_cnt + 1;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_val;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic bit mis(input txn_t t);
    return (int'(t.addr[2:0]) % nbytes(t.size)) != 0;
  endfunction

  function automatic logic [63:0] load_val(input logic [63:0] w, input txn_t t);
    logic [7:0]  b [8];
    logic [63:0] v = 64'd0;
    int n = nbytes(t.size);
    int off = int'(t.addr[2:0]);
    for (int i = 0; i < 8; i++) b[i] = w[8*i +: 8];
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | {56'd0, b[off+i]};
    if (!t.uns && n < 8 && b[off+n-1][7]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [63:0] store_val(input logic [63:0] w, input txn_t t);
    logic [63:0] r = w;
    int off = int'(t.addr[2:0]);
    for (int i = 0; i < nbytes(t.size); i++) r[8*(off+i) +: 8] = t.wdata[8*i +: 8];
    return r;
  endfunction

  function automatic txn_t mk(input logic we, input logic [7:0] addr, input logic [1:0] size,
                              input logic uns, input logic [63:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.size = size; t.uns = uns; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.size  = 2'($urandom_range(0, 3));
    t.uns   = 1'($urandom_range(0, 1));
    t.addr  = 8'($urandom_range(0, 255));
    t.wdata = {$urandom, $urandom};
    if ($urandom_range(0, 4) != 0) t.addr[2:0] = t.addr[2:0] & 3'(~((1 << t.size) - 1));
    return t;
  endfunction

  task automatic drive(input int r, input logic req, input txn_t t);
    if (r == 0) begin
      c0_req = req; c0_we = t.we; c0_addr = t.addr; c0_size = t.size; c0_uns = t.uns; c0_wdata = t.wdata;
    end else begin
      c1_req = req; c1_we = t.we; c1_addr = t.addr; c1_size = t.size; c1_uns = t.uns; c1_wdata = t.wdata;
    end
  endtask

  // Issue one or two requests from IDLE and check ack timing, data, error and memory writes.
  task automatic run(input bit a0, input txn_t t0, input bit a1, input txn_t t1, input bit scr);
    txn_t        tq [2];
    int          order [2];
    int          exp_cyc [2];
    logic [63:0] exp_rd [2];
    logic        exp_err [2];
    bit          done [2];
    int          nord, exp_wr, cyc, base, w0, we_cyc;
    tq[0] = t0; tq[1] = t1;
    exp_wr = 0; cyc = 0; base = 0; we_cyc = -1; first_acked = -1;
    exp_cyc[0] = -1; exp_cyc[1] = -1;
    if (a0 && a1) begin
      order[0] = (last_model == 0) ? 1 : 0; order[1] = 1 - order[0]; nord = 2;
    end else begin
      order[0] = a0 ? 0 : 1; order[1] = -1; nord = 1;
    end
    for (int k = 0; k < nord; k++) begin
      int r = order[k];
      int idx = int'(tq[r].addr[7:3]);
      int lat;
      last_model = r;
      exp_rd[r]  = 64'd0;
      exp_err[r] = mis(tq[r]);
      if (exp_err[r]) lat = 1;
      else if (!tq[r].we) begin
        lat = 2; exp_rd[r] = load_val(model[idx], tq[r]);
      end else begin
        lat = (tq[r].size == 2'b11) ? 2 : 3;
        model[idx] = store_val(model[idx], tq[r]);
        exp_wr++;
      end
      exp_cyc[r] = base + lat;
      base = base + lat + 1;
    end
    chk("idle_busy", {63'd0, busy}, 64'd0);
    w0 = wr_cnt;
    done[0] = !a0; done[1] = !a1;
    drive(0, a0, t0);
    drive(1, a1, t1);
    while (!(done[0] && done[1]) && cyc < 16) begin
      logic        ak [2];
      logic        er [2];
      logic [63:0] rd [2];
      @(posedge clk); #1; cyc++;
      if (mem_We && we_cyc < 0) we_cyc = cyc;
      ak[0] = c0_ack; er[0] = c0_err; rd[0] = c0_rdata;
      ak[1] = c1_ack; er[1] = c1_err; rd[1] = c1_rdata;
      for (int r = 0; r < 2; r++) begin
        if (ak[r] && done[r]) chk($sformatf("c%0d_spurious_ack", r), 64'd1, 64'd0);
        else if (ak[r]) begin
          chk($sformatf("c%0d_ack_cycle", r), 64'(cyc), 64'(exp_cyc[r]));
          chk($sformatf("c%0d_rdata", r), rd[r], exp_rd[r]);
          chk($sformatf("c%0d_err", r), {63'd0, er[r]}, {63'd0, exp_err[r]});
          done[r] = 1'b1; last_rd[r] = rd[r];
          if (first_acked < 0) first_acked = r;
          if (r == 0) c0_req = 1'b0; else c1_req = 1'b0;
        end else begin
          chk($sformatf("c%0d_err_noack", r), {63'd0, er[r]}, 64'd0);
        end
      end
      if (scr && cyc == 1 && nord == 1 && !done[order[0]]) drive(order[0], 1'b1, rnd_txn());
    end
    for (int r = 0; r < 2; r++)
      if (!done[r]) chk($sformatf("c%0d_ack_timeout", r), 64'd0, 64'd1);
    c0_req = 1'b0; c1_req = 1'b0;
    @(posedge clk); #1;
    chk("write_count", 64'(wr_cnt - w0), 64'(exp_wr));
    if (nord == 1 && exp_wr == 1) chk("write_cycle", 64'(we_cyc), 64'(exp_cyc[order[0]] - 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; last_model = 1;
  endtask

  txn_t        none;
  txn_t        tt;
  logic [63:0] saved;
  int          w_save;

  initial begin
    none = mk(1'b0, 8'h00, 2'b00, 1'b0, 64'd0);
    drive(0, 1'b0, none);
    drive(1, 1'b0, none);
    rst_n = 1'b0;
    // Preload memory while the DUT is held in reset.
    for (int i = 0; i < DEPTH; i++) begin
      bd_we = 1'b1; bd_idx = 5'(i);
      bd_val = (i == 3) ? 64'h1122334455667788 : {$urandom, $urandom};
      model[i] = bd_val;
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
    chk("rst_ack_err", {60'd0, c0_ack, c1_ack, c0_err, c1_err}, 64'd0);
    chk("rst_c0_rdata", c0_rdata, 64'd0);
    chk("rst_c1_rdata", c1_rdata, 64'd0);
    chk("rst_mem_we_busy", {62'd0, mem_We, busy}, 64'd0);
    chk("rst_mem_endr", {59'd0, mem_endr}, 64'd0);
    chk("rst_mem_din", mem_din, 64'd0);
    rst_n = 1'b1; last_model = 1;

    // Signed byte load from the top lane of word 3.
    run(1'b1, mk(1'b0, 8'h1F, 2'b00, 1'b0, 64'd0), 1'b0, none, 1'b0);
    chk("byte_load_value", last_rd[0], 64'h0000000000000011);
    // Half store merged into word 3.
    run(1'b1, mk(1'b1, 8'h1A, 2'b01, 1'b0, 64'h000000000000BEEF), 1'b0, none, 1'b0);
    chk("half_store_word3", mem[3], 64'h11223344BEEF7788);
    // Misaligned word load from c1.
    run(1'b0, none, 1'b1, mk(1'b0, 8'h06, 2'b10, 1'b0, 64'd0), 1'b0);
    chk("misaligned_rdata", last_rd[1], 64'd0);
    // Word load sign/zero extension through a double store of the pattern.
    run(1'b1, mk(1'b1, 8'h08, 2'b11, 1'b0, 64'h0000000080000000), 1'b0, none, 1'b0);
    run(1'b1, mk(1'b0, 8'h08, 2'b10, 1'b0, 64'd0), 1'b0, none, 1'b0);
    chk("word_load_signed", last_rd[0], 64'hFFFFFFFF80000000);
    run(1'b1, mk(1'b0, 8'h08, 2'b10, 1'b1, 64'd0), 1'b0, none, 1'b0);
    chk("word_load_unsigned", last_rd[0], 64'h0000000080000000);

    // Simultaneous requests after reset: c0 first, then alternation.
    do_reset();
    run(1'b1, mk(1'b0, 8'h18, 2'b11, 1'b0, 64'd0), 1'b1, mk(1'b0, 8'h10, 2'b11, 1'b0, 64'd0), 1'b0);
    chk("tie_first_grant", 64'(first_acked), 64'd0);
    run(1'b1, rnd_txn(), 1'b1, rnd_txn(), 1'b0);
    chk("tie_second_round", 64'(first_acked), 64'd0);

    // Reset asserted in the merge cycle of a byte store.
    tt = mk(1'b1, 8'h21, 2'b00, 1'b0, 64'h00000000000000A5);
    saved = mem[4]; w_save = wr_cnt;
    drive(0, 1'b1, tt);
    repeat (2) begin @(posedge clk); #1; end
    chk("merge_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0; #1;
    chk("merge_rst_we_gated", {63'd0, mem_We}, 64'd0);
    @(posedge clk); #1;
    chk("merge_rst_ack", {62'd0, c0_ack, c1_ack}, 64'd0);
    chk("merge_rst_busy", {63'd0, busy}, 64'd0);
    chk("merge_rst_no_write", 64'(wr_cnt - w_save), 64'd0);
    chk("merge_rst_mem", mem[4], saved);
    c0_req = 1'b0; rst_n = 1'b1; last_model = 1;

    // Randomized traffic: c0 only, c1 only, or both, with occasional field scrambling after grant.
    for (int k = 0; k < 150; k++) begin
      int mode = $urandom_range(0, 2);
      run(mode != 1, rnd_txn(), mode != 0, rnd_txn(), $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_final_%0d", i), mem[i], model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
